// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control FSM.
// Covers ALU op codes, opcode/funct values and the 4-bit state encoding.
package mc_pkg;

   localparam int OPW = 6;

   localparam logic [OPW-1:0] ALU_NOP = 6'b000000;
   localparam logic [OPW-1:0] ALU_ADD = 6'b100000;
   localparam logic [OPW-1:0] ALU_SUB = 6'b100010;
   localparam logic [OPW-1:0] ALU_AND = 6'b100100;
   localparam logic [OPW-1:0] ALU_OR  = 6'b100101;
   localparam logic [OPW-1:0] ALU_XOR = 6'b100110;
   localparam logic [OPW-1:0] ALU_NOR = 6'b100111;

   localparam logic [OPW-1:0] OP_R    = 6'b000000;
   localparam logic [OPW-1:0] OP_J    = 6'b000010;
   localparam logic [OPW-1:0] OP_BEQ  = 6'b000100;
   localparam logic [OPW-1:0] OP_BNE  = 6'b000101;
   localparam logic [OPW-1:0] OP_ADDI = 6'b001000;
   localparam logic [OPW-1:0] OP_ANDI = 6'b001100;
   localparam logic [OPW-1:0] OP_ORI  = 6'b001101;
   localparam logic [OPW-1:0] OP_XORI = 6'b001110;
   localparam logic [OPW-1:0] OP_LW   = 6'b100011;
   localparam logic [OPW-1:0] OP_SW   = 6'b101011;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_REXE   = 4'd7,
      S_RWB    = 4'd8,
      S_BRANCH = 4'd9,
      S_IEXE   = 4'd10,
      S_IWB    = 4'd11,
      S_JUMP   = 4'd12,
      S_HALT   = 4'd13
   } state_t;

   function automatic logic is_alu_funct(logic [OPW-1:0] f);
      return f inside {ALU_ADD, ALU_SUB, ALU_AND,
                       ALU_OR, ALU_XOR, ALU_NOR};
   endfunction

   function automatic logic is_opcode(logic [OPW-1:0] op);
      return op inside {OP_R, OP_J, OP_BEQ, OP_BNE,
                        OP_ADDI, OP_ANDI, OP_ORI,
                        OP_XORI, OP_LW, OP_SW};
   endfunction

endpackage

// File: rtl/mc_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave).
interface mc_if;
   import mc_pkg::*;

   logic [OPW-1:0] opcode;
   logic [OPW-1:0] funct;
   logic           zero;
   logic [OPW-1:0] alu_op;
   logic           alu_src_a;
   logic [1:0]     alu_src_b;
   logic           ext_zero;
   logic [1:0]     pc_src;
   logic           pc_en;
   logic           i_or_d;
   logic           mem_read;
   logic           mem_write;
   logic           ir_write;
   logic           reg_dst;
   logic           mem_to_reg;
   logic           reg_write;
   logic           illegal;
   logic [3:0]     state_o;

   modport master (
      input  opcode, funct, zero,
      output alu_op, alu_src_a, alu_src_b, ext_zero,
      output pc_src, pc_en, i_or_d,
      output mem_read, mem_write, ir_write,
      output reg_dst, mem_to_reg, reg_write,
      output illegal, state_o
   );

   modport slave (
      output opcode, funct, zero,
      input  alu_op, alu_src_a, alu_src_b, ext_zero,
      input  pc_src, pc_en, i_or_d,
      input  mem_read, mem_write, ir_write,
      input  reg_dst, mem_to_reg, reg_write,
      input  illegal, state_o
   );

endinterface

// File: rtl/mc_alu_op_dec.sv
// ALU op / extension / legality decode from {state, opcode, funct}.
module mc_alu_op_dec
   import mc_pkg::*;
(
   input  state_t         state,
   input  logic [OPW-1:0] opcode,
   input  logic [OPW-1:0] funct,
   output logic [OPW-1:0] alu_op,
   output logic           ext_zero,
   output logic           legal
);

   always_comb begin
      alu_op   = ALU_NOP;
      ext_zero = 1'b0;
      legal    = 1'b1;
      unique case (state)
         S_FETCH, S_MEMADR: alu_op = ALU_ADD;
         S_DECODE: begin
            alu_op = ALU_ADD;
            legal  = is_opcode(opcode);
         end
         S_BRANCH: alu_op = ALU_SUB;
         // Bad funct falls back to NOP so alu_op stays in the code set
         S_REXE: begin
            if (is_alu_funct(funct)) alu_op = funct;
            else                     legal  = 1'b0;
         end
         S_IEXE: begin
            unique case (opcode)
               OP_ADDI: alu_op = ALU_ADD;
               OP_ANDI: begin alu_op = ALU_AND; ext_zero = 1'b1; end
               OP_ORI:  begin alu_op = ALU_OR;  ext_zero = 1'b1; end
               OP_XORI: begin alu_op = ALU_XOR; ext_zero = 1'b1; end
               default: alu_op = ALU_NOP;
            endcase
         end
         default: alu_op = ALU_NOP;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// Multicycle control FSM: fetch/decode/execute sequencing and datapath selects.
// MC_CTRL_ILLEGAL_TRAP_EN: illegal instructions lock the FSM in HALT until reset.
module mc_control
   import mc_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   mc_if.master bus
);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   localparam bit     TRAP    = 1'b1;
   localparam state_t ILL_NXT = S_HALT;
`else
   localparam bit     TRAP    = 1'b0;
   localparam state_t ILL_NXT = S_FETCH;
`endif

   state_t         state;
   logic [OPW-1:0] alu_op;
   logic           ext_zero;
   logic           legal;

   mc_alu_op_dec u_dec (
      .state    (state),
      .opcode   (bus.opcode),
      .funct    (bus.funct),
      .alu_op   (alu_op),
      .ext_zero (ext_zero),
      .legal    (legal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:   state <= S_FETCH;
            S_FETCH:  state <= S_DECODE;
            S_DECODE: begin
               unique case (1'b1)
                  !legal:                 state <= ILL_NXT;
                  bus.opcode == OP_LW,
                  bus.opcode == OP_SW:    state <= S_MEMADR;
                  bus.opcode == OP_R:     state <= S_REXE;
                  bus.opcode == OP_BEQ,
                  bus.opcode == OP_BNE:   state <= S_BRANCH;
                  bus.opcode == OP_J:     state <= S_JUMP;
                  default:                state <= S_IEXE;
               endcase
            end
            S_MEMADR: state <= (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state <= S_MEMWB;
            S_REXE:   state <= legal ? S_RWB : ILL_NXT;
            S_IEXE:   state <= S_IWB;
            S_MEMWB, S_MEMWR, S_RWB, S_IWB,
            S_BRANCH, S_JUMP: state <= S_FETCH;
            // Without the trap build HALT is dead and recovers like a bad code
            S_HALT:   state <= TRAP ? S_HALT : S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

   assign bus.alu_op   = alu_op;
   assign bus.ext_zero = ext_zero;
   assign bus.state_o  = state;
   assign bus.illegal  = !legal || (TRAP && state == S_HALT);

   always_comb begin
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.pc_src     = 2'b00;
      bus.pc_en      = 1'b0;
      bus.i_or_d     = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.reg_write  = 1'b0;
      unique case (state)
         S_FETCH: begin
            bus.mem_read  = 1'b1;
            bus.ir_write  = 1'b1;
            bus.alu_src_b = 2'b01;
            bus.pc_en     = 1'b1;
         end
         S_DECODE: bus.alu_src_b = 2'b11;
         S_MEMADR, S_IEXE: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            bus.mem_read = 1'b1;
            bus.i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            bus.mem_write = 1'b1;
            bus.i_or_d    = 1'b1;
         end
         S_REXE: bus.alu_src_a = 1'b1;
         S_RWB: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 1'b1;
         end
         S_IWB: bus.reg_write = 1'b1;
         S_BRANCH: begin
            bus.alu_src_a = 1'b1;
            bus.pc_src    = 2'b01;
            bus.pc_en     = (bus.opcode == OP_BEQ) ? bus.zero : ~bus.zero;
         end
         S_JUMP: begin
            bus.pc_src = 2'b10;
            bus.pc_en  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: driver queues per-cycle expectations, monitor checks.
module tb_mc_control;
   import mc_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   mc_if bus();

   mc_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [5:0] alu_op;
      logic       sa;
      logic [1:0] sb;
      logic       ez;
      logic [1:0] ps;
      logic       pe, iod, mr, mw, irw, rd, m2r, rw, ill;
      logic [3:0] st;
   } out_t;

   typedef struct {
      string nm;
      out_t  v;
   } item_t;

   item_t q[$];
   int errors = 0;
   int checks = 0;

   function automatic out_t z(state_t s);
      out_t e = '0;
      e.st = s;
      return e;
   endfunction

   function automatic out_t e_fetch();
      out_t e = z(S_FETCH);
      e.alu_op = 6'b100000; e.sb = 2'b01;
      e.pe = 1; e.mr = 1; e.irw = 1;
      return e;
   endfunction

   function automatic out_t e_decode(logic ill);
      out_t e = z(S_DECODE);
      e.alu_op = 6'b100000; e.sb = 2'b11; e.ill = ill;
      return e;
   endfunction

   function automatic out_t e_memadr();
      out_t e = z(S_MEMADR);
      e.alu_op = 6'b100000; e.sa = 1; e.sb = 2'b10;
      return e;
   endfunction

   function automatic out_t e_memrd();
      out_t e = z(S_MEMRD);
      e.mr = 1; e.iod = 1;
      return e;
   endfunction

   function automatic out_t e_memwb();
      out_t e = z(S_MEMWB);
      e.rw = 1; e.m2r = 1;
      return e;
   endfunction

   function automatic out_t e_memwr();
      out_t e = z(S_MEMWR);
      e.mw = 1; e.iod = 1;
      return e;
   endfunction

   function automatic out_t e_rexe(logic [5:0] a, logic ill);
      out_t e = z(S_REXE);
      e.alu_op = a; e.sa = 1; e.ill = ill;
      return e;
   endfunction

   function automatic out_t e_rwb();
      out_t e = z(S_RWB);
      e.rw = 1; e.rd = 1;
      return e;
   endfunction

   function automatic out_t e_iexe(logic [5:0] a, logic ez);
      out_t e = z(S_IEXE);
      e.alu_op = a; e.sa = 1; e.sb = 2'b10; e.ez = ez;
      return e;
   endfunction

   function automatic out_t e_iwb();
      out_t e = z(S_IWB);
      e.rw = 1;
      return e;
   endfunction

   function automatic out_t e_branch(logic pe);
      out_t e = z(S_BRANCH);
      e.alu_op = 6'b100010; e.sa = 1; e.ps = 2'b01; e.pe = pe;
      return e;
   endfunction

   function automatic out_t e_jump();
      out_t e = z(S_JUMP);
      e.ps = 2'b10; e.pe = 1;
      return e;
   endfunction

   function automatic out_t e_halt();
      out_t e = z(S_HALT);
      e.ill = 1;
      return e;
   endfunction

   function automatic out_t act();
      out_t a;
      a.alu_op = bus.alu_op;     a.sa  = bus.alu_src_a;
      a.sb     = bus.alu_src_b;  a.ez  = bus.ext_zero;
      a.ps     = bus.pc_src;     a.pe  = bus.pc_en;
      a.iod    = bus.i_or_d;     a.mr  = bus.mem_read;
      a.mw     = bus.mem_write;  a.irw = bus.ir_write;
      a.rd     = bus.reg_dst;    a.m2r = bus.mem_to_reg;
      a.rw     = bus.reg_write;  a.ill = bus.illegal;
      a.st     = bus.state_o;
      return a;
   endfunction

   task automatic cyc(string nm, out_t e);
      item_t it;
      @(posedge clk); #1;
      it.nm = nm;
      it.v  = e;
      q.push_back(it);
   endtask

   task automatic start(logic [5:0] op, logic [5:0] fn, logic zf, logic ill);
      item_t it;
      @(posedge clk); #1;
      bus.opcode = op;
      bus.funct  = fn;
      bus.zero   = zf;
      it.nm = "fetch";
      it.v  = e_fetch();
      q.push_back(it);
      cyc("decode", e_decode(ill));
   endtask

   task automatic reset_seq();
      item_t it;
      @(posedge clk); #1;
      rst_n = 1'b0;
      it.nm = "rst_assert";
      it.v  = z(S_IDLE);
      q.push_back(it);
      cyc("rst_hold", z(S_IDLE));
      @(posedge clk); #1;
      rst_n = 1'b1;
      it.nm = "rst_release";
      q.push_back(it);
   endtask

   task automatic trap_tail();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      repeat (10) cyc("halt", e_halt());
      reset_seq();
`endif
   endtask

   initial begin
      item_t it;
      out_t  a;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            it = q.pop_front();
            a  = act();
            checks++;
            if (a !== it.v) begin
               errors++;
               $display("FAIL %s: got %h want %h", it.nm, a, it.v);
            end
         end
      end
   end

   initial begin
      bus.opcode = '0;
      bus.funct  = '0;
      bus.zero   = 1'b0;
      reset_seq();

      // R-type
      start(6'b000000, 6'b100000, 0, 0);
      cyc("rexe_add", e_rexe(6'b100000, 0));
      cyc("rwb", e_rwb());
      start(6'b000000, 6'b100010, 0, 0);
      cyc("rexe_sub", e_rexe(6'b100010, 0));
      cyc("rwb", e_rwb());
      start(6'b000000, 6'b100111, 0, 0);
      cyc("rexe_nor", e_rexe(6'b100111, 0));
      cyc("rwb", e_rwb());

      // lw / sw
      start(6'b100011, 6'b000000, 0, 0);
      cyc("lw_memadr", e_memadr());
      cyc("lw_memrd", e_memrd());
      cyc("lw_memwb", e_memwb());
      start(6'b101011, 6'b000000, 0, 0);
      cyc("sw_memadr", e_memadr());
      cyc("sw_memwr", e_memwr());

      // branches
      start(6'b000100, 6'b000000, 1, 0);
      cyc("beq_z1", e_branch(1));
      start(6'b000100, 6'b000000, 0, 0);
      cyc("beq_z0", e_branch(0));
      start(6'b000101, 6'b000000, 1, 0);
      cyc("bne_z1", e_branch(0));
      start(6'b000101, 6'b000000, 0, 0);
      cyc("bne_z0", e_branch(1));

      // immediates
      start(6'b001000, 6'b000000, 0, 0);
      cyc("addi_iexe", e_iexe(6'b100000, 0));
      cyc("iwb", e_iwb());
      start(6'b001101, 6'b000000, 0, 0);
      cyc("ori_iexe", e_iexe(6'b100101, 1));
      cyc("iwb", e_iwb());
      start(6'b001100, 6'b000000, 0, 0);
      cyc("andi_iexe", e_iexe(6'b100100, 1));
      cyc("iwb", e_iwb());
      start(6'b001110, 6'b000000, 0, 0);
      cyc("xori_iexe", e_iexe(6'b100110, 1));
      cyc("iwb", e_iwb());

      // jump
      start(6'b000010, 6'b000000, 0, 0);
      cyc("j_jump", e_jump());

      // illegal opcode / funct
      start(6'b111111, 6'b000000, 0, 1);
      trap_tail();
      start(6'b000000, 6'b101010, 0, 0);
      cyc("rexe_bad", e_rexe(6'b000000, 1));
      trap_tail();

      // recovery, then reset in the middle of lw
      start(6'b000000, 6'b100100, 0, 0);
      cyc("rexe_and", e_rexe(6'b100100, 0));
      cyc("rwb", e_rwb());
      start(6'b100011, 6'b000000, 0, 0);
      reset_seq();
      start(6'b001000, 6'b000000, 0, 0);
      cyc("addi_iexe", e_iexe(6'b100000, 0));
      cyc("iwb", e_iwb());

      repeat (4) @(negedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
